power_toggle_monitor: RTL and testbench

//  Switching-activity monitor placed directly downstream of a power-benchmark combinational sub-circuit.

---
 rtl/power_mon_pkg.sv | 18 +
 rtl/power_mon_popcount.sv | 19 +
 rtl/power_toggle_monitor.sv | 137 +++++++++++++
 tb/tb_power_toggle_monitor.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/power_mon_pkg.sv
// rtl/power_mon_pkg.sv - shared state encoding and popcount width helper for the toggle monitor
package power_mon_pkg;

  localparam int PM_STATE_W = 2;

  typedef enum logic [PM_STATE_W-1:0] {
    PM_IDLE = 2'd0,
    PM_ARM  = 2'd1,
    PM_RUN  = 2'd2,
    PM_DONE = 2'd3
  } pm_state_e;

  // Bits needed to hold a count of 0..width set bits.
  function automatic int pm_pc_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/power_mon_popcount.sv
// rtl/power_mon_popcount.sv - combinational population count of a WIDTH-bit vector
module power_mon_popcount
  import power_mon_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int OUT_W = pm_pc_width(WIDTH)
) (
  input  logic [WIDTH-1:0] sig_i,
  output logic [OUT_W-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_o = cnt_o + OUT_W'(sig_i[i]);
    end
  end

endmodule

// File: rtl/power_toggle_monitor.sv
// rtl/power_toggle_monitor.sv - windowed toggle/high-cycle counter with valid/ready result port
// Build option: POWER_MON_SATURATE_EN clamps the accumulators instead of wrapping them.
module power_toggle_monitor
  import power_mon_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIN_W-1:0] win_len_i,
  input  logic [WIDTH-1:0] sig_i,
  output logic             busy_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [CNT_W-1:0] res_tog_o,
  output logic [CNT_W-1:0] res_ones_o,
  output logic             res_ovf_o
);

  localparam int PC_W = pm_pc_width(WIDTH);

  pm_state_e        state_q, state_d;
  logic [WIN_W-1:0] win_len_q, win_len_d;
  logic [WIN_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] tog_q, tog_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;

  logic [PC_W-1:0]  tog_pc;
  logic [PC_W-1:0]  ones_pc;
  logic [CNT_W:0]   tog_sum;
  logic [CNT_W:0]   ones_sum;
  logic [WIN_W:0]   cnt_next;

  power_mon_popcount #(.WIDTH(WIDTH), .OUT_W(PC_W)) u_pc_tog (
    .sig_i (sig_i ^ prev_q),
    .cnt_o (tog_pc)
  );

  power_mon_popcount #(.WIDTH(WIDTH), .OUT_W(PC_W)) u_pc_ones (
    .sig_i (sig_i),
    .cnt_o (ones_pc)
  );

  // The extra top bit of each sum is the carry that flags overflow.
  assign tog_sum  = {1'b0, tog_q} + (CNT_W+1)'(tog_pc);
  assign ones_sum = {1'b0, ones_q} + (CNT_W+1)'(ones_pc);
  assign cnt_next = {1'b0, cnt_q} + (WIN_W+1)'(1);

  always_comb begin
    state_d   = state_q;
    win_len_d = win_len_q;
    cnt_d     = cnt_q;
    prev_d    = prev_q;
    tog_d     = tog_q;
    ones_d    = ones_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      PM_IDLE: begin
        if (start_i && (win_len_i != '0)) begin
          state_d   = PM_ARM;
          win_len_d = win_len_i;
          tog_d     = '0;
          ones_d    = '0;
          ovf_d     = 1'b0;
        end
      end
      PM_ARM: begin
        prev_d  = sig_i;
        cnt_d   = '0;
        state_d = PM_RUN;
      end
      PM_RUN: begin
        prev_d = sig_i;
        cnt_d  = cnt_next[WIN_W-1:0];
`ifdef POWER_MON_SATURATE_EN
        tog_d  = tog_sum[CNT_W]  ? '1 : tog_sum[CNT_W-1:0];
        ones_d = ones_sum[CNT_W] ? '1 : ones_sum[CNT_W-1:0];
`else
        tog_d  = tog_sum[CNT_W-1:0];
        ones_d = ones_sum[CNT_W-1:0];
`endif
        ovf_d  = ovf_q | tog_sum[CNT_W] | ones_sum[CNT_W];
        if (cnt_next == {1'b0, win_len_q}) begin
          state_d = PM_DONE;
        end
      end
      PM_DONE: begin
        if (res_ready_i) begin
          state_d = PM_IDLE;
        end
      end
      default: state_d = PM_IDLE;
    endcase

    busy_d  = (state_d != PM_IDLE);
    valid_d = (state_d == PM_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PM_IDLE;
      win_len_q <= '0;
      cnt_q     <= '0;
      prev_q    <= '0;
      tog_q     <= '0;
      ones_q    <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_len_q <= win_len_d;
      cnt_q     <= cnt_d;
      prev_q    <= prev_d;
      tog_q     <= tog_d;
      ones_q    <= ones_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  assign busy_o      = busy_q;
  assign res_valid_o = valid_q;
  assign res_tog_o   = tog_q;
  assign res_ones_o  = ones_q;
  assign res_ovf_o   = ovf_q;

endmodule

// File: tb/tb_power_toggle_monitor.sv
// tb/tb_power_toggle_monitor.sv - directed checks of a 16-bit and a 4-bit accumulator instance
module tb_power_toggle_monitor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] win_len;
  logic        sig;
  logic        res_ready;

  logic        busy_a, valid_a, ovf_a;
  logic [15:0] tog_a, ones_a;
  logic        busy_b, valid_b, ovf_b;
  logic [3:0]  tog_b, ones_b;

  int checks = 0;
  int errors = 0;

`ifdef POWER_MON_SATURATE_EN
  localparam int EXP_B20 = 15;
`else
  localparam int EXP_B20 = 4;
`endif

  power_toggle_monitor #(.WIDTH(1), .CNT_W(16), .WIN_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start), .win_len_i(win_len), .sig_i(sig),
    .busy_o(busy_a), .res_valid_o(valid_a), .res_ready_i(res_ready),
    .res_tog_o(tog_a), .res_ones_o(ones_a), .res_ovf_o(ovf_a)
  );

  power_toggle_monitor #(.WIDTH(1), .CNT_W(4), .WIN_W(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start), .win_len_i(win_len), .sig_i(sig),
    .busy_o(busy_b), .res_valid_o(valid_b), .res_ready_i(res_ready),
    .res_tog_o(tog_b), .res_ones_o(ones_b), .res_ovf_o(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic busy_e, input logic valid_e);
    check({tag, " busy_a"}, 32'(busy_a), 32'(busy_e));
    check({tag, " valid_a"}, 32'(valid_a), 32'(valid_e));
    check({tag, " busy_b"}, 32'(busy_b), 32'(busy_e));
    check({tag, " valid_b"}, 32'(valid_b), 32'(valid_e));
  endtask

  task automatic check_res(input string tag, input int tog_ae, input int ones_ae, input logic ovf_ae,
                           input int tog_be, input int ones_be, input logic ovf_be);
    check({tag, " tog_a"}, 32'(tog_a), 32'(tog_ae));
    check({tag, " ones_a"}, 32'(ones_a), 32'(ones_ae));
    check({tag, " ovf_a"}, 32'(ovf_a), 32'(ovf_ae));
    check({tag, " tog_b"}, 32'(tog_b), 32'(tog_be));
    check({tag, " ones_b"}, 32'(ones_b), 32'(ones_be));
    check({tag, " ovf_b"}, 32'(ovf_b), 32'(ovf_be));
  endtask

  // Start a window of n samples; sig_i is init_v during ARM, then optionally inverted before every sample.
  task automatic run_window(input string tag, input int n, input logic init_v, input logic toggle);
    start   = 1'b1;
    win_len = 16'(n);
    tick();
    start   = 1'b0;
    win_len = 16'd2;
    sig     = init_v;
    check_ctl({tag, " arm"}, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) check_ctl({tag, " pre_last"}, 1'b1, 1'b0);
      if (toggle) sig = ~sig;
      tick();
    end
    check_ctl({tag, " done"}, 1'b1, 1'b1);
  endtask

  task automatic handshake(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_ctl({tag, " after_hs"}, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    win_len   = '0;
    sig       = 1'b0;
    res_ready = 1'b0;
    tick();
    tick();
    check_ctl("reset", 1'b0, 1'b0);
    check_res("reset", 0, 0, 1'b0, 0, 0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Alternating 1,0,... after 0 at ARM: every sample toggles, half are high.
    run_window("t1", 8, 1'b0, 1'b1);
    check_res("t1", 8, 4, 1'b0, 8, 4, 1'b0);
    handshake("t1");
    check_res("t1 hold", 8, 4, 1'b0, 8, 4, 1'b0);

    run_window("t2", 5, 1'b1, 1'b0);
    check_res("t2", 0, 5, 1'b0, 0, 5, 1'b0);
    handshake("t2");

    start   = 1'b1;
    win_len = 16'd0;
    tick();
    check_ctl("t3 first", 1'b0, 1'b0);
    repeat (3) tick();
    check_ctl("t3 later", 1'b0, 1'b0);
    start = 1'b0;

    run_window("t4", 8, 1'b0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      start   = (c == 3);
      win_len = 16'd5;
      sig     = c[0];
      tick();
      check_ctl("t4 stall", 1'b1, 1'b1);
      check_res("t4 stall", 8, 4, 1'b0, 8, 4, 1'b0);
    end
    start     = 1'b1;
    res_ready = 1'b1;
    tick();
    start     = 1'b0;
    res_ready = 1'b0;
    check_ctl("t4 hs", 1'b0, 1'b0);
    tick();
    check_ctl("t4 no_queue", 1'b0, 1'b0);

    run_window("t5 tog", 20, 1'b0, 1'b1);
    check_res("t5 tog", 20, 10, 1'b0, EXP_B20, 10, 1'b1);
    handshake("t5 tog");

    run_window("t5 ones", 20, 1'b1, 1'b0);
    check_res("t5 ones", 0, 20, 1'b0, 0, EXP_B20, 1'b1);
    handshake("t5 ones");
    check_res("t5 hold", 0, 20, 1'b0, 0, EXP_B20, 1'b1);

    start   = 1'b1;
    win_len = 16'd8;
    tick();
    start = 1'b0;
    sig   = 1'b0;
    tick();
    repeat (3) begin
      sig = ~sig;
      tick();
    end
    check_res("t6 mid", 3, 2, 1'b0, 3, 2, 1'b0);
    rst_n = 1'b0;
    #1;
    check_ctl("t6 rst", 1'b0, 1'b0);
    check_res("t6 rst", 0, 0, 1'b0, 0, 0, 1'b0);
    #2;
    rst_n = 1'b1;
    tick();
    check_ctl("t6 idle", 1'b0, 1'b0);
    run_window("t6 rerun", 3, 1'b0, 1'b1);
    check_res("t6 rerun", 3, 2, 1'b0, 3, 2, 1'b0);
    handshake("t6 rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
